// File: rtl/delta2_sdp_ram_pkg.sv
// Shared accelerator defines for the delta2 buffer: default geometry, the delta
// word type and the read-latency to pipeline-depth mapping.
package delta2_sdp_ram_pkg;

  localparam int DELTA_BRAM_AWIDTH_DFLT = 15;
  localparam int DELTA_BRAM_DWIDTH_DFLT = 36;

  typedef logic signed [DELTA_BRAM_DWIDTH_DFLT-1:0] delta_t;

  // Stage 1 lives next to the array; the remaining latency is a plain register chain.
  // Out-of-range latencies are clamped into the supported 1..3 window.
  function automatic int pipe_stages(input int read_latency);
    int lat;
    lat = read_latency;
    if (lat < 1) lat = 1;
    if (lat > 3) lat = 3;
    return lat - 1;
  endfunction

endpackage

// File: rtl/delta2_sdp_ram_pipe.sv
// Trailing read-data/valid shift register for the delta2 RAM; STAGES may be 0,
// in which case the input passes straight through.
module delta2_sdp_ram_pipe #(
  parameter int DATA_W = 36,
  parameter int STAGES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              vld_in,
  output logic [DATA_W-1:0] dout,
  output logic              vld_out
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dout    = din;
    assign vld_out = vld_in;
  end else begin : g_regs
    logic [DATA_W-1:0] data_p [STAGES];
    logic              vld_p  [STAGES];

    // Every stage shifts each cycle, so a held stage-1 value drains out unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < STAGES; i++) begin
          data_p[i] <= '0;
          vld_p[i]  <= 1'b0;
        end
      end else begin
        data_p[0] <= din;
        vld_p[0]  <= vld_in;
        for (int i = 1; i < STAGES; i++) begin
          data_p[i] <= data_p[i-1];
          vld_p[i]  <= vld_p[i-1];
        end
      end
    end

    assign dout    = data_p[STAGES-1];
    assign vld_out = vld_p[STAGES-1];
  end

endmodule

// File: rtl/delta2_sdp_ram.sv
// Simple-dual-port delta2 buffer RAM: write port A, read-first pipelined read
// port B with a matching valid; behavioural stand-in for the vendor block-RAM IP.
module delta2_sdp_ram
  import delta2_sdp_ram_pkg::*;
#(
  parameter int DELTA_BRAM_AWIDTH = DELTA_BRAM_AWIDTH_DFLT,
  parameter int DELTA_BRAM_DWIDTH = DELTA_BRAM_DWIDTH_DFLT,
  parameter int READ_LATENCY      = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         wea,
  input  logic [DELTA_BRAM_AWIDTH-1:0] addra,
  input  logic [DELTA_BRAM_DWIDTH-1:0] dina,
  input  logic                         enb,
  input  logic [DELTA_BRAM_AWIDTH-1:0] addrb,
  output logic [DELTA_BRAM_DWIDTH-1:0] doutb,
  output logic                         doutb_valid
);

  localparam int DEPTH  = 2 ** DELTA_BRAM_AWIDTH;
  localparam int STAGES = pipe_stages(READ_LATENCY);

  // Array contents survive reset; only the configuration-time image is zero.
  logic [DELTA_BRAM_DWIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [DELTA_BRAM_DWIDTH-1:0] rd_p0;
  logic                         vld_p0;

  always_ff @(posedge clk) begin
    if (rst_n && ena && wea) begin
      mem[addra] <= dina;
    end
  end

  // Stage 0: array read, read-first against a same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p0  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= enb;
      if (enb) begin
        rd_p0 <= mem[addrb];
      end
    end
  end

  // Stage 1..: remaining latency.
  delta2_sdp_ram_pipe #(
    .DATA_W (DELTA_BRAM_DWIDTH),
    .STAGES (STAGES)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (rd_p0),
    .vld_in  (vld_p0),
    .dout    (doutb),
    .vld_out (doutb_valid)
  );

endmodule

// File: tb/tb_delta2_sdp_ram.sv
// Bench for delta2_sdp_ram: three instances (latency 1, 2, 3) share one stimulus
// stream and are checked every cycle against an edge-indexed history model.
module tb_delta2_sdp_ram;

  localparam int AW    = 5;
  localparam int DW    = 36;
  localparam int DEPTH = 32;
  localparam int HMAX  = 8192;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena   = 1'b0;
  logic          wea   = 1'b0;
  logic          enb   = 1'b0;
  logic [AW-1:0] addra = '0;
  logic [AW-1:0] addrb = '0;
  logic [DW-1:0] dina  = '0;

  logic [DW-1:0] dout [1:3];
  logic          vld  [1:3];

  always #5 clk = ~clk;

  delta2_sdp_ram #(.DELTA_BRAM_AWIDTH(AW), .DELTA_BRAM_DWIDTH(DW), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(dout[1]), .doutb_valid(vld[1]));

  delta2_sdp_ram #(.DELTA_BRAM_AWIDTH(AW), .DELTA_BRAM_DWIDTH(DW), .READ_LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(dout[2]), .doutb_valid(vld[2]));

  delta2_sdp_ram #(.DELTA_BRAM_AWIDTH(AW), .DELTA_BRAM_DWIDTH(DW), .READ_LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(dout[3]), .doutb_valid(vld[3]));

  // Reference: memory image plus, per clock edge, the value the read port
  // returned at that edge (or held from an earlier read) and whether one was issued.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] hist_d  [HMAX];
  logic          hist_v  [HMAX];
  logic [DW-1:0] last_rd;
  int            edge_n;
  int            reset_edge;
  int            n_checks;
  int            n_fail;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input int lat);
    int idx;
    idx = edge_n - lat + 1;
    return (idx > reset_edge) ? hist_d[idx] : '0;
  endfunction

  function automatic logic exp_valid(input int lat);
    int idx;
    idx = edge_n - lat + 1;
    return (idx > reset_edge) ? hist_v[idx] : 1'b0;
  endfunction

  task automatic check_outputs(input string tag);
    for (int l = 1; l <= 3; l++) begin
      chk_eq($sformatf("%s_l%0d_data", tag, l), 64'(dout[l]), 64'(exp_data(l)));
      chk_eq($sformatf("%s_l%0d_vld", tag, l), 64'(vld[l]), 64'(exp_valid(l)));
    end
  endtask

  task automatic model_edge();
    edge_n++;
    if (!rst_n) begin
      reset_edge = edge_n;
      last_rd    = '0;
    end else begin
      if (enb) last_rd = ref_mem[addrb];
      hist_d[edge_n] = last_rd;
      hist_v[edge_n] = enb;
      if (ena && wea) ref_mem[addra] = dina;
    end
  endtask

  task automatic cycle(input logic a_en, input logic a_we, input logic [AW-1:0] a_addr,
                       input logic [DW-1:0] a_data, input logic b_en,
                       input logic [AW-1:0] b_addr, input string tag);
    ena   = a_en;
    wea   = a_we;
    addra = a_addr;
    dina  = a_data;
    enb   = b_en;
    addrb = b_addr;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n      = 1'b0;
    reset_edge = edge_n;
    last_rd    = '0;
    #1;
    check_outputs(tag);
    chk_eq({tag, "_l3_zero"}, 64'(dout[3]), 64'd0);
    chk_eq({tag, "_l2_vld_zero"}, 64'(vld[2]), 64'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    edge_n     = 0;
    reset_edge = 0;
    last_rd    = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int i = 0; i < HMAX; i++) begin
      hist_d[i] = '0;
      hist_v[i] = 1'b0;
    end

    #1;
    check_outputs("reset");
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, AW'(7), DW'(99), 1'b1, '0, "in_reset");
    rst_n = 1'b1;

    cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(0), "pwr0");
    chk_eq("pwr0_d", 64'(dout[1]), 64'd0);
    chk_eq("pwr0_v", 64'(vld[1]), 64'd1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(1), "pwr1");
    chk_eq("pwr1_d", 64'(dout[1]), 64'd0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(2), "pwr2");
    chk_eq("pwr2_v", 64'(vld[1]), 64'd1);
    chk_eq("write_ignored_in_reset", 64'(ref_mem[7]), 64'd0);

    cycle(1'b1, 1'b1, AW'(0), DW'(3), 1'b0, '0, "wr0");
    cycle(1'b1, 1'b1, AW'(1), DW'(5), 1'b0, '0, "wr1");
    cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(0), "rd0");
    chk_eq("rd0_d", 64'(dout[1]), 64'd3);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(1), "rd1");
    chk_eq("rd1_d", 64'(dout[1]), 64'd5);

    cycle(1'b1, 1'b1, AW'(0), DW'(5), 1'b1, AW'(0), "collide");
    chk_eq("collide_old", 64'(dout[1]), 64'd3);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(0), "after_collide");
    chk_eq("after_collide_new", 64'(dout[1]), 64'd5);

    cycle(1'b0, 1'b1, AW'(3), DW'(8), 1'b0, '0, "ena_off_wr");
    cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(3), "ena_off_rd");
    chk_eq("ena_off_blocks", 64'(dout[1]), 64'd0);
    cycle(1'b1, 1'b1, AW'(3), DW'(8), 1'b0, '0, "ena_on_wr");
    cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(3), "ena_on_rd");
    chk_eq("ena_on_writes", 64'(dout[1]), 64'd8);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(4), "rd4");
    chk_eq("rd4_zero", 64'(dout[1]), 64'd0);

    cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(1), "l2_req");
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, "l2_drain");
    chk_eq("l2_data", 64'(dout[2]), 64'd5);
    chk_eq("l2_vld", 64'(vld[2]), 64'd1);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, "l2_hold");
    chk_eq("l2_hold_data", 64'(dout[2]), 64'd5);
    chk_eq("l2_hold_vld", 64'(vld[2]), 64'd0);

    cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(1), "inflight");
    async_reset("async_rst");
    @(negedge clk);
    cycle(1'b1, 1'b1, AW'(1), DW'(9), 1'b0, '0, "wr_in_reset");
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(1), "post_rst");
    chk_eq("post_rst_preserved", 64'(dout[1]), 64'd5);

    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) begin
        async_reset("rand_rst");
        @(negedge clk);
        cycle(1'($urandom), 1'($urandom), AW'($urandom), DW'({$urandom, $urandom}),
              1'($urandom), AW'($urandom), "rand_in_rst");
        rst_n = 1'b1;
      end
      cycle(1'($urandom), 1'($urandom), AW'($urandom), DW'({$urandom, $urandom}),
            ($urandom_range(0, 9) < 7), AW'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delta2_sdp_ram.md
Name: delta2_sdp_ram

Overview:
- Single-clock simple-dual-port RAM holding delta values for the accelerator's delta2 buffer: one write port (A), one read port (B).
- Drop-in behavioural replacement for the vendor delta2 block-RAM IP, with identical A/B port naming.
- Producers update entries through port A while the consumer issues independent reads through port B.

Parameters:
- DELTA_BRAM_AWIDTH, 15, address width; depth = 2**DELTA_BRAM_AWIDTH words.
- DELTA_BRAM_DWIDTH, 36, data word width.
- READ_LATENCY, 1, cycles from read request to doutb; legal values 1..3.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  port-A enable; a write needs ena=1.
- wea  in  1  write enable; write occurs when ena & wea.
- addra  in  AWIDTH  write address.
- dina  in  DWIDTH  write data.
- enb  in  1  read enable (read request).
- addrb  in  AWIDTH  read address.
- doutb  out  DWIDTH  read data.
- doutb_valid  out  1  doutb carries the response to a request issued READ_LATENCY cycles earlier.

Behaviour:
- Storage: 2**AWIDTH x DWIDTH array, initialised to all-zero at time 0 / configuration. Reset does not clear the array.
- Write: on a clk edge with ena=1 and wea=1, mem[addra] <= dina. Otherwise the array is unchanged; ena=0 blocks writes regardless of wea.
- Read: on a clk edge with enb=1, mem[addrb] is captured into stage 1. Each extra stage up to READ_LATENCY is a plain register.
  - doutb equals the final stage, so data appears READ_LATENCY edges after the request edge.
  - doutb_valid follows the same pipeline, fed by enb.
- enb=0:
  - The stage-1 data register holds its value, so doutb holds the last read data once the pipeline drains.
  - doutb_valid goes 0 after READ_LATENCY edges.
- Same-address collision (enb & ena & wea & addra==addrb on one edge) is read-first: the read returns the old contents; the new value is visible to reads on later edges.
- Back-to-back reads: one per cycle, fully pipelined, no stalls, no back-pressure.
- Addresses wrap naturally within AWIDTH; there is no out-of-range case.
- Reset (rst_n=0, asynchronous):
  - All pipeline data registers go to 0; doutb=0 and doutb_valid=0.
  - In-flight reads are discarded.
  - Writes presented while rst_n=0 are ignored.
  - After deassertion, the first request behaves normally.
- Unknown (X) inputs during reset are don't-care; after reset, enb and ena must be driven.

Decomposition:
- Shared package (accelerator defines): DELTA_BRAM_AWIDTH and DELTA_BRAM_DWIDTH defaults, plus a delta word typedef.
- One natural sub-module: delta2_sdp_ram_pipe, a parameterised READ_LATENCY-1 stage data+valid shift register with async reset.
- Array and write logic stay in the top so synthesis infers block RAM.

Test Plan:
- Power-up read, no writes: enb=1, read addr 0, 1, 2 on consecutive cycles -> doutb=0 with doutb_valid=1, each one cycle after its request (READ_LATENCY=1).
- Write then read: write addr 0 = 3, then addr 1 = 5, then read addr 0 and 1 -> 3 and 5 respectively.
- Collision and overwrite:
  - Addr 0 holds 3; write addr 0 = 5 while reading addr 0 on the same edge -> read returns 3.
  - A read of addr 0 on the next edge -> 5.
- Write-enable gating:
  - ena=0, wea=1, addra=3, dina=8, then read addr 3 -> 0.
  - Repeat with ena=1 -> 8.
  - Read addr 4 -> 0.
- Read-enable hold and latency: READ_LATENCY=2, read addr 1 (=5), then drop enb -> doutb=5 two edges after the request; doutb stays 5 with doutb_valid=0 afterwards.
- Async reset mid-stream: assert rst_n=0 between clk edges while a read is in flight -> doutb=0 and doutb_valid=0 immediately. After release, reading addr 1 still returns 5 (array preserved).
